// File: rtl/pad_event_generator_if.sv
// Pad event bus: raw pad inputs in, debounced press/release pulses and levels out.
interface pad_event_generator_if #(
  parameter int NUM_KEYS = 12
);
  logic [NUM_KEYS-1:0] i_key_raw;
  logic [NUM_KEYS-1:0] o_event;
  logic [NUM_KEYS-1:0] o_release_evt;
  logic [NUM_KEYS-1:0] o_held;
  logic                o_key_any;

  modport master (
    output i_key_raw,
    input  o_event, o_release_evt, o_held, o_key_any
  );

  modport slave (
    input  i_key_raw,
    output o_event, o_release_evt, o_held, o_key_any
  );
endinterface

// File: rtl/pad_event_generator.sv
// Launchpad front end: synchronise, debounce and edge-detect raw pads,
// with optional auto-repeat while a pad is held.
module pad_event_generator #(
  parameter int NUM_KEYS       = 12,
  parameter int TICK_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 10,
  parameter int REPEAT_EN      = 0,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_PERIOD  = 100,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  pad_event_generator_if.slave   bus
);

  localparam int TW      = $clog2(TICK_DIV);
  localparam int CNT_W   = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  localparam logic [NUM_KEYS-1:0] REL_LVL  = (KEY_ACTIVE_LOW != 0) ? {NUM_KEYS{1'b1}} : {NUM_KEYS{1'b0}};
  localparam logic [TW-1:0]       TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]    DB_LAST   = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [RW-1:0]       DEL_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0]       PER_LAST  = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [NUM_KEYS-1:0] w_p;
  logic [TW-1:0]       r_tick_cnt;
  logic                w_tick;

  state_t              r_state     [NUM_KEYS];
  state_t              w_state_nxt [NUM_KEYS];
  logic [CNT_W-1:0]    r_cnt       [NUM_KEYS];
  logic [CNT_W-1:0]    w_cnt_nxt   [NUM_KEYS];
  logic [RW-1:0]       r_rcnt      [NUM_KEYS];
  logic [RW-1:0]       w_rcnt_nxt  [NUM_KEYS];
  // r_phase = 0 while waiting for the first repeat, 1 once repeating at PERIOD
  logic [NUM_KEYS-1:0] r_phase;
  logic [NUM_KEYS-1:0] w_phase_nxt;

  logic [NUM_KEYS-1:0] w_event_nxt;
  logic [NUM_KEYS-1:0] w_rel_nxt;
  logic [NUM_KEYS-1:0] w_held_nxt;
  logic [NUM_KEYS-1:0] r_event;
  logic [NUM_KEYS-1:0] r_release;
  logic [NUM_KEYS-1:0] r_held;
  logic                r_key_any;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync1 <= REL_LVL;
      r_sync2 <= REL_LVL;
    end else begin
      r_sync1 <= bus.i_key_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_p    = (KEY_ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;
  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        r_state[k] <= RELEASED;
        r_cnt[k]   <= '0;
        r_rcnt[k]  <= '0;
      end
      r_phase   <= '0;
      r_event   <= '0;
      r_release <= '0;
      r_held    <= '0;
      r_key_any <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        r_state[k] <= w_state_nxt[k];
        r_cnt[k]   <= w_cnt_nxt[k];
        r_rcnt[k]  <= w_rcnt_nxt[k];
      end
      r_phase   <= w_phase_nxt;
      r_event   <= w_event_nxt;
      r_release <= w_rel_nxt;
      r_held    <= w_held_nxt;
      r_key_any <= |w_held_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rcnt_nxt  = r_rcnt;
    w_phase_nxt = r_phase;
    w_event_nxt = '0;
    w_rel_nxt   = '0;
    w_held_nxt  = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      case (r_state[k])
        RELEASED: begin
          if (w_p[k]) begin
            w_state_nxt[k] = DB_PRESS;
            w_cnt_nxt[k]   = '0;
          end
        end
        DB_PRESS: begin
          if (!w_p[k]) begin
            w_state_nxt[k] = RELEASED;
          end else if (w_tick) begin
            if (r_cnt[k] == DB_LAST) begin
              w_state_nxt[k] = PRESSED;
              w_rcnt_nxt[k]  = '0;
              w_phase_nxt[k] = 1'b0;
              w_event_nxt[k] = 1'b1;
            end else begin
              w_cnt_nxt[k] = r_cnt[k] + CNT_W'(1);
            end
          end
        end
        PRESSED: begin
          if (!w_p[k]) begin
            w_state_nxt[k] = DB_RELEASE;
            w_cnt_nxt[k]   = '0;
          end else if ((REPEAT_EN != 0) && w_tick) begin
            // >= rather than == keeps the counter from ever wrapping past the limit
            if (r_rcnt[k] >= (r_phase[k] ? PER_LAST : DEL_LAST)) begin
              w_event_nxt[k] = 1'b1;
              w_rcnt_nxt[k]  = '0;
              w_phase_nxt[k] = 1'b1;
            end else begin
              w_rcnt_nxt[k] = r_rcnt[k] + RW'(1);
            end
          end
        end
        DB_RELEASE: begin
          if (w_p[k]) begin
            w_state_nxt[k] = PRESSED;
          end else if (w_tick) begin
            if (r_cnt[k] == DB_LAST) begin
              w_state_nxt[k] = RELEASED;
              w_rel_nxt[k]   = 1'b1;
            end else begin
              w_cnt_nxt[k] = r_cnt[k] + CNT_W'(1);
            end
          end
        end
        default: w_state_nxt[k] = RELEASED;
      endcase
      w_held_nxt[k] = (w_state_nxt[k] == PRESSED) || (w_state_nxt[k] == DB_RELEASE);
    end
  end

  assign bus.o_event       = r_event;
  assign bus.o_release_evt = r_release;
  assign bus.o_held        = r_held;
  assign bus.o_key_any     = r_key_any;

endmodule

// File: tb/tb_pad_event_generator.sv
// Directed bench for pad_event_generator: press, bounce, repeat, release, simultaneous, reset.
module tb_pad_event_generator;
  localparam int NK = 12;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  pad_event_generator_if #(.NUM_KEYS(NK)) bus ();

  pad_event_generator #(
    .NUM_KEYS(NK), .TICK_DIV(4), .DEBOUNCE_TICKS(3), .REPEAT_EN(1),
    .REPEAT_DELAY(5), .REPEAT_PERIOD(2), .KEY_ACTIVE_LOW(1)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_evt(input int b, input int maxc, output int lat);
    int i;
    lat = 0;
    i = 0;
    while (lat == 0 && i < maxc) begin
      i = i + 1;
      cyc();
      if (bus.o_event[b]) lat = i;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, total, first, extra, evcnt;
    logic [NK-1:0] ev, hd, rv, other;
    logic ka, held_ok;
    logic [2:0] sticky;

    bus.i_key_raw = '1;
    #1 RST = 1'b0;
    #2;
    chk("rst_event",   32'(bus.o_event), 0);
    chk("rst_release", 32'(bus.o_release_evt), 0);
    chk("rst_held",    32'(bus.o_held), 0);
    chk("rst_key_any", 32'(bus.o_key_any), 0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    repeat (12) cyc();
    chk("idle_held", 32'(bus.o_held), 0);

    // Clean press on pad 0
    @(negedge CLK);
    bus.i_key_raw[0] = 1'b0;
    lat = 0; other = '0; ev = '0; hd = '0; ka = 1'b0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      cyc();
      if (bus.o_event[0]) begin
        lat = i; ev = bus.o_event; hd = bus.o_held; ka = bus.o_key_any;
      end else begin
        other = other | bus.o_event | bus.o_release_evt;
      end
    end
    chk("press_latency_12_15", 32'(lat >= 12 && lat <= 15), 1);
    chk("press_event_vec", 32'(ev), 32'h001);
    chk("press_held_vec",  32'(hd), 32'h001);
    chk("press_key_any",   32'(ka), 1);
    chk("press_no_other",  32'(other), 0);
    extra = 0; held_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (bus.o_event != '0) extra++;
      if (bus.o_held != 12'h001) held_ok = 1'b0;
    end
    chk("press_single_event", 32'(extra), 0);
    chk("press_held_stable",  32'(held_ok), 1);

    // Release pad 0
    @(negedge CLK);
    bus.i_key_raw[0] = 1'b1;
    lat = 0; evcnt = 0; held_ok = 1'b1; rv = '0; hd = '1; ka = 1'b1;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      cyc();
      if (bus.o_event != '0) evcnt++;
      if (bus.o_release_evt[0]) begin
        lat = i; rv = bus.o_release_evt; hd = bus.o_held; ka = bus.o_key_any;
      end else if (!bus.o_held[0]) begin
        held_ok = 1'b0;
      end
    end
    chk("rel_latency_12_15", 32'(lat >= 12 && lat <= 15), 1);
    chk("rel_pulse_vec",     32'(rv), 32'h001);
    chk("rel_held_falls",    32'(hd), 0);
    chk("rel_key_any",       32'(ka), 0);
    chk("rel_no_event",      32'(evcnt), 0);
    chk("rel_held_through_db", 32'(held_ok), 1);
    cyc();
    chk("rel_one_cycle", 32'(bus.o_release_evt), 0);

    // Bounce on pad 2: 5-cycle half periods are shorter than the debounce window
    sticky = '0;
    for (int i = 0; i < 80; i++) begin
      @(negedge CLK);
      if (i < 60 && (i % 5) == 0) bus.i_key_raw[2] = ~bus.i_key_raw[2];
      cyc();
      sticky = sticky | {bus.o_event[2], bus.o_held[2], bus.o_release_evt[2]};
    end
    chk("bounce_key_high", 32'(bus.i_key_raw[2]), 1);
    chk("bounce_no_event",   32'(sticky[2]), 0);
    chk("bounce_no_held",    32'(sticky[1]), 0);
    chk("bounce_no_release", 32'(sticky[0]), 0);

    // Auto-repeat on pad 1 over 60 ticks after acceptance
    @(negedge CLK);
    bus.i_key_raw[1] = 1'b0;
    wait_evt(1, 20, lat);
    chk("rpt_accept_latency", 32'(lat >= 12 && lat <= 15), 1);
    total = (lat != 0) ? 1 : 0;
    first = 0;
    for (int i = 1; i <= 240; i++) begin
      cyc();
      if (bus.o_event[1]) begin
        total++;
        if (first == 0) first = i;
      end
    end
    chk("rpt_first_offset", 32'(first), 20);
    chk("rpt_total_pulses", 32'(total), 29);
    @(negedge CLK);
    bus.i_key_raw[1] = 1'b1;
    repeat (25) cyc();
    chk("rpt_released", 32'(bus.o_held), 0);

    // Pads 3 and 11 pressed together
    @(negedge CLK);
    bus.i_key_raw[3]  = 1'b0;
    bus.i_key_raw[11] = 1'b0;
    ev = '0; hd = '0;
    for (int i = 1; i <= 20 && ev == '0; i++) begin
      cyc();
      if (bus.o_event != '0) begin
        ev = bus.o_event; hd = bus.o_held;
      end
    end
    chk("simul_event_vec", 32'(ev), 32'h808);
    chk("simul_held_vec",  32'(hd), 32'h808);
    @(negedge CLK);
    bus.i_key_raw[3]  = 1'b1;
    bus.i_key_raw[11] = 1'b1;
    repeat (25) cyc();
    chk("simul_key_any_off", 32'(bus.o_key_any), 0);

    // Reset while pad 5 is pulsing
    @(negedge CLK);
    bus.i_key_raw[5] = 1'b0;
    wait_evt(5, 20, lat);
    chk("rst_mid_event_seen", 32'(bus.o_event), 32'h020);
    RST = 1'b0;
    #1;
    chk("rst_mid_event",   32'(bus.o_event), 0);
    chk("rst_mid_held",    32'(bus.o_held), 0);
    chk("rst_mid_key_any", 32'(bus.o_key_any), 0);
    @(negedge CLK);
    RST = 1'b1;
    wait_evt(5, 20, lat);
    chk("rst_after_latency", 32'(lat), 12);
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      if (bus.o_event != '0) extra++;
    end
    chk("rst_after_single_event", 32'(extra), 0);
    @(negedge CLK);
    bus.i_key_raw[5] = 1'b1;
    repeat (25) cyc();
    chk("final_held",    32'(bus.o_held), 0);
    chk("final_key_any", 32'(bus.o_key_any), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
